perip_bus_arbiter: RTL and testbench
====================================

Name: perip_bus_arbiter

Overview:
- Shares the single 8-bit peripheral bus (address, write data, rd/wr strobes, read data) between two masters: M0 = Processor, M1 = secondary master (debug/DMA).
- Sits between the masters and the top-level peripheral decode block. Peripherals register read data one cycle after the rd strobe.
- Round-robin arbitration; one access in flight at a time.
- Uniform req/ack handshake with configurable wait states for slow peripherals.

Parameters:
- WAIT_STATES, 0: extra cycles held in RESP before sampling read data and acking (0..15).

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_m0_req  in  1  M0 access request; held with fields stable until ack
- i_m0_wr  in  1  1 = write, 0 = read
- i_m0_addr  in  8  M0 peripheral address
- i_m0_wdata  in  8  M0 write data
- o_m0_ack  out  1  one-cycle pulse: M0 access complete
- o_m0_rdata  out  8  M0 read data, valid while o_m0_ack = 1, held until next M0 read
- i_m1_req, i_m1_wr, i_m1_addr[8], i_m1_wdata[8], o_m1_ack, o_m1_rdata[8]  same meaning for M1
- o_perip_addr  out  8  bus address
- o_perip_wdata  out  8  bus write data
- o_perip_wr  out  1  write strobe, one cycle
- o_perip_rd  out  1  read strobe, one cycle
- i_perip_rdata  in  8  peripheral read data, valid from the cycle after o_perip_rd
- o_busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (i_rst_n = 0 at an edge), from any state:
  - State -> IDLE; wait counter -> 0.
  - All outputs 0: strobes, acks, rdata, addr, wdata, busy.
  - Round-robin pointer last_gnt -> M1, so M0 wins the first tie.
  - Any access in flight is abandoned: no ack is issued.
- All outputs are registered.
- FSM states: IDLE, STROBE, RESP.
- IDLE:
  - Eligible requester: req = 1 AND its ack is not high this cycle. This stops a master that still holds req in its ack cycle from being re-granted.
  - Neither eligible: stay in IDLE.
  - One eligible: grant it.
  - Both eligible: grant the master that is not last_gnt.
  - On grant: latch owner, wr, addr and wdata; update last_gnt; go to STROBE.
  - At the same edge, drive o_perip_addr and o_perip_wdata, and set o_perip_wr or o_perip_rd.
- STROBE (cycle t+1, grant sampled at t):
  - Exactly one strobe high for this single cycle.
  - addr and wdata stable.
  - Strobes clear at the next edge; go to RESP.
- RESP:
  - Wait counter counts 0..WAIT_STATES.
  - When the counter equals WAIT_STATES:
    - Read: capture i_perip_rdata into the owner's rdata.
    - Both directions: set the owner's ack for one cycle, return to IDLE, counter -> 0.
- Latency: request sampled at t -> strobe at t+1 -> ack at t+3+WAIT_STATES.
- Read data sampled at the end of cycle t+2+WAIT_STATES.
- Throughput: one access per 3+WAIT_STATES cycles when requests are back to back.
- A write ack leaves rdata unchanged.
- o_perip_addr and o_perip_wdata hold their last values after the access (no return to 0).
- The non-owner's ack is never asserted.
- Both acks are never high together.
- A req dropped before ack does not cancel the access; the ack is still issued.
- A req that falls while in STROBE or RESP is ignored until IDLE.

Test Plan:
- Reset: hold i_rst_n = 0 for 2 cycles with both reqs high -> all outputs 0, no strobe; after release, M0 is granted first.
- M0 read:
  - Stimulus: addr 0x00; model returns 0x01 one cycle after rd.
  - Response: o_perip_rd high only at t+1 with addr 0x00; o_m0_ack at t+3 with o_m0_rdata = 0x01; o_m1_ack stays 0.
- Contention:
  - Stimulus: M0 writes 0x03 to addr 0x01 while M1 writes 0x01 to addr 0x02; both hold req across three accesses, each master dropping req after its ack.
  - Response: bus order M0, M1, then M0 again only if M0 re-requests; each o_perip_wr pulse lasts one cycle with the correct addr/wdata.
- Held req: M1 keeps req high through its ack cycle, then drops it one cycle later -> exactly one strobe; no second grant.
- WAIT_STATES = 2, M1 read of addr 0x04 (model data 0xA5) -> ack at t+5, o_m1_rdata = 0xA5, o_busy high t+1..t+5.
- Reset mid-operation:
  - Stimulus: assert i_rst_n = 0 during STROBE of an M0 read.
  - Response: strobe 0 after that edge; no o_m0_ack; a new M0 request after release completes normally with 3-cycle latency.

Source files
------------

// File: rtl/perip_bus_arbiter_if.sv
// perip_bus_arbiter_if: request/ack ports of both masters plus the shared peripheral bus
interface perip_bus_arbiter_if;
  logic       i_m0_req;
  logic       i_m0_wr;
  logic [7:0] i_m0_addr;
  logic [7:0] i_m0_wdata;
  logic       o_m0_ack;
  logic [7:0] o_m0_rdata;
  logic       i_m1_req;
  logic       i_m1_wr;
  logic [7:0] i_m1_addr;
  logic [7:0] i_m1_wdata;
  logic       o_m1_ack;
  logic [7:0] o_m1_rdata;
  logic [7:0] o_perip_addr;
  logic [7:0] o_perip_wdata;
  logic       o_perip_wr;
  logic       o_perip_rd;
  logic [7:0] i_perip_rdata;
  logic       o_busy;
  modport slave (
    input  i_m0_req, i_m0_wr, i_m0_addr, i_m0_wdata,
    input  i_m1_req, i_m1_wr, i_m1_addr, i_m1_wdata,
    input  i_perip_rdata,
    output o_m0_ack, o_m0_rdata, o_m1_ack, o_m1_rdata,
    output o_perip_addr, o_perip_wdata, o_perip_wr, o_perip_rd, o_busy
  );
  modport master (
    output i_m0_req, i_m0_wr, i_m0_addr, i_m0_wdata,
    output i_m1_req, i_m1_wr, i_m1_addr, i_m1_wdata,
    output i_perip_rdata,
    input  o_m0_ack, o_m0_rdata, o_m1_ack, o_m1_rdata,
    input  o_perip_addr, o_perip_wdata, o_perip_wr, o_perip_rd, o_busy
  );
endinterface

// File: rtl/perip_bus_arbiter.sv
// perip_bus_arbiter: round-robin sharing of one peripheral bus between two masters
module perip_bus_arbiter #(
  parameter int unsigned WAIT_STATES = 0
) (
  input logic                i_clk,
  input logic                i_rst_n,
  perip_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, STROBE, RESP} state_t;
  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_last;
  logic       r_owner;
  logic       r_wr;
  logic       w_e0;
  logic       w_e1;
  logic       w_g1;
  logic       w_wr;
  // a master still holding req during its own ack cycle is not re-granted
  assign w_e0 = bus.i_m0_req & ~bus.o_m0_ack;
  assign w_e1 = bus.i_m1_req & ~bus.o_m1_ack;
  assign w_g1 = w_e1 & (~w_e0 | ~r_last);
  assign w_wr = w_g1 ? bus.i_m1_wr : bus.i_m0_wr;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state           <= IDLE;
      r_cnt             <= 4'd0;
      r_last            <= 1'b1;
      r_owner           <= 1'b0;
      r_wr              <= 1'b0;
      bus.o_m0_ack      <= 1'b0;
      bus.o_m1_ack      <= 1'b0;
      bus.o_m0_rdata    <= 8'd0;
      bus.o_m1_rdata    <= 8'd0;
      bus.o_perip_addr  <= 8'd0;
      bus.o_perip_wdata <= 8'd0;
      bus.o_perip_wr    <= 1'b0;
      bus.o_perip_rd    <= 1'b0;
      bus.o_busy        <= 1'b0;
    end else begin
      bus.o_m0_ack <= 1'b0;
      bus.o_m1_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          bus.o_busy <= w_e0 | w_e1;
          if (w_e0 | w_e1) begin
            r_owner           <= w_g1;
            r_last            <= w_g1;
            r_wr              <= w_wr;
            bus.o_perip_addr  <= w_g1 ? bus.i_m1_addr : bus.i_m0_addr;
            bus.o_perip_wdata <= w_g1 ? bus.i_m1_wdata : bus.i_m0_wdata;
            bus.o_perip_wr    <= w_wr;
            bus.o_perip_rd    <= ~w_wr;
            r_state           <= STROBE;
          end
        end
        STROBE: begin
          bus.o_perip_wr <= 1'b0;
          bus.o_perip_rd <= 1'b0;
          r_cnt          <= 4'd0;
          r_state        <= RESP;
        end
        RESP: begin
          if (r_cnt == 4'(WAIT_STATES)) begin
            if (!r_wr && r_owner) bus.o_m1_rdata <= bus.i_perip_rdata;
            if (!r_wr && !r_owner) bus.o_m0_rdata <= bus.i_perip_rdata;
            bus.o_m0_ack <= ~r_owner;
            bus.o_m1_ack <= r_owner;
            r_cnt        <= 4'd0;
            r_state      <= IDLE;
          end else r_cnt <= r_cnt + 4'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_perip_bus_arbiter.sv
// tb_perip_bus_arbiter: arbiters with 0 and 2 wait states fed by queued masters, checked against a latency/round-robin model
module tb_perip_bus_arbiter;
  typedef struct {
    logic       wr;
    logic [7:0] a;
    logic [7:0] d;
    bit         hold;
    int         gap;
  } txn_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  txn_t       q [4][$];
  logic       req [4];
  logic       wr [4];
  logic [7:0] ad [4];
  logic [7:0] wd [4];
  bit         act [4];
  bit         hold [4];
  bit         drop [4];
  int         gap [4];
  logic [3:0] ack;
  logic [7:0] rdat [4];
  logic [1:0] pwr, prd, busy;
  logic [7:0] paddr [2];
  logic [7:0] pwdata [2];
  logic [7:0] prdata [2];
  logic [7:0] mem [2][256];
  int vecs = 0;
  int errs = 0;
  int nedge = 0;
  bit         pend [2];
  bit         own [2];
  bit         pwrm [2];
  int         ack_at [2];
  bit         last1 [2];
  logic [7:0] e_addr [2];
  logic [7:0] e_wd [2];
  logic [7:0] pend_rd [2];
  logic [7:0] e_rd [4];
  logic [3:0] eack_prev = 4'd0;
  for (genvar g = 0; g < 2; g++) begin : u
    perip_bus_arbiter_if bus ();
    perip_bus_arbiter #(.WAIT_STATES(2 * g)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
    assign bus.i_m0_req      = req[2*g];
    assign bus.i_m0_wr       = wr[2*g];
    assign bus.i_m0_addr     = ad[2*g];
    assign bus.i_m0_wdata    = wd[2*g];
    assign bus.i_m1_req      = req[2*g+1];
    assign bus.i_m1_wr       = wr[2*g+1];
    assign bus.i_m1_addr     = ad[2*g+1];
    assign bus.i_m1_wdata    = wd[2*g+1];
    assign bus.i_perip_rdata = prdata[g];
    assign ack[2*g]          = bus.o_m0_ack;
    assign ack[2*g+1]        = bus.o_m1_ack;
    assign rdat[2*g]         = bus.o_m0_rdata;
    assign rdat[2*g+1]       = bus.o_m1_rdata;
    assign pwr[g]            = bus.o_perip_wr;
    assign prd[g]            = bus.o_perip_rd;
    assign busy[g]           = bus.o_busy;
    assign paddr[g]          = bus.o_perip_addr;
    assign pwdata[g]         = bus.o_perip_wdata;
  end
  // peripheral: registers read data one cycle after rd and holds it until the next read
  initial begin
    for (int g = 0; g < 2; g++) begin
      prdata[g] = 8'd0;
      for (int i = 0; i < 256; i++) mem[g][i] = 8'(i * 13 + g * 7 + 8'h3c);
      mem[g][0] = 8'h01;
      mem[g][4] = 8'ha5;
    end
    forever begin
      @(posedge clk);
      for (int g = 0; g < 2; g++) begin
        if (pwr[g]) mem[g][paddr[g]] <= pwdata[g];
        if (prd[g]) prdata[g] <= mem[g][paddr[g]];
      end
    end
  end
  task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
    vecs++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s @edge %0d: got %0h want %0h", tag, nedge, got, want);
    end
  endtask
  task automatic check();
    logic [1:0] ea;
    logic ewr, erd, eb;
    bit e0, e1, gm;
    int k;
    nedge++;
    for (int g = 0; g < 2; g++) begin
      ea = 2'b00;
      ewr = 1'b0;
      erd = 1'b0;
      eb = 1'b0;
      if (!rst_n) begin
        pend[g] = 1'b0;
        last1[g] = 1'b1;
        e_addr[g] = 8'd0;
        e_wd[g] = 8'd0;
        e_rd[2*g] = 8'd0;
        e_rd[2*g+1] = 8'd0;
      end else if (pend[g]) begin
        eb = 1'b1;
        if (nedge == ack_at[g]) begin
          ea[own[g]] = 1'b1;
          if (!pwrm[g]) e_rd[2*g+int'(own[g])] = pend_rd[g];
          pend[g] = 1'b0;
        end
      end else begin
        e0 = req[2*g] && !eack_prev[2*g];
        e1 = req[2*g+1] && !eack_prev[2*g+1];
        if (e0 || e1) begin
          gm = (e0 && e1) ? !last1[g] : e1;
          k = 2 * g + int'(gm);
          last1[g] = gm;
          own[g] = gm;
          pend[g] = 1'b1;
          ack_at[g] = nedge + 2 + 2 * g;
          pwrm[g] = wr[k];
          pend_rd[g] = mem[g][ad[k]];
          ewr = wr[k];
          erd = !wr[k];
          eb = 1'b1;
          e_addr[g] = ad[k];
          e_wd[g] = wd[k];
        end
      end
      eack_prev[2*g +: 2] = ea;
      chk($sformatf("u%0d.m0_ack", g), ack[2*g], ea[0]);
      chk($sformatf("u%0d.m1_ack", g), ack[2*g+1], ea[1]);
      chk($sformatf("u%0d.m0_rdata", g), rdat[2*g], e_rd[2*g]);
      chk($sformatf("u%0d.m1_rdata", g), rdat[2*g+1], e_rd[2*g+1]);
      chk($sformatf("u%0d.perip_wr", g), pwr[g], ewr);
      chk($sformatf("u%0d.perip_rd", g), prd[g], erd);
      chk($sformatf("u%0d.perip_addr", g), paddr[g], e_addr[g]);
      chk($sformatf("u%0d.perip_wdata", g), pwdata[g], e_wd[g]);
      chk($sformatf("u%0d.busy", g), busy[g], eb);
    end
  endtask
  // masters: hold req with stable fields until ack, optionally keeping req one cycle past the ack
  task automatic drive();
    txn_t t;
    for (int k = 0; k < 4; k++) begin
      if (drop[k]) begin
        req[k] = 1'b0;
        act[k] = 1'b0;
        drop[k] = 1'b0;
      end else if (req[k] && ack[k]) begin
        if (hold[k]) drop[k] = 1'b1;
        else begin
          req[k] = 1'b0;
          act[k] = 1'b0;
        end
      end else if (!act[k] && q[k].size() != 0) begin
        t = q[k].pop_front();
        wr[k] = t.wr;
        ad[k] = t.a;
        wd[k] = t.d;
        hold[k] = t.hold;
        gap[k] = t.gap;
        act[k] = 1'b1;
      end
      if (act[k] && !req[k]) begin
        if (gap[k] == 0) req[k] = 1'b1;
        else gap[k]--;
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1 check();
    @(negedge clk);
    drive();
  endtask
  task automatic push(int g, int m, logic w, logic [7:0] a, logic [7:0] d, bit h, int gp);
    q[2*g+m].push_back(txn_t'{w, a, d, h, gp});
  endtask
  function automatic bit pending();
    for (int k = 0; k < 4; k++) if (act[k] || req[k] || q[k].size() != 0) return 1'b1;
    return 1'b0;
  endfunction
  task automatic wait_idle();
    int n;
    n = 0;
    while (n < 3000 && pending()) begin
      tick();
      n++;
    end
    chk("idle_wait_expired", 32'(n >= 3000), 32'd0);
    repeat (2) tick();
  endtask
  initial begin
    int n;
    for (int k = 0; k < 4; k++) begin
      req[k] = 1'b0;
      wr[k] = 1'b0;
      ad[k] = 8'd0;
      wd[k] = 8'd0;
      act[k] = 1'b0;
      hold[k] = 1'b0;
      drop[k] = 1'b0;
      gap[k] = 0;
    end
    for (int g = 0; g < 2; g++) begin
      pend[g] = 1'b0;
      last1[g] = 1'b1;
      push(g, 0, 1'b0, 8'h00, 8'h00, 1'b0, 0);
      push(g, 1, 1'b0, 8'h04, 8'h00, 1'b0, 0);
    end
    @(negedge clk);
    drive();
    repeat (2) tick();
    rst_n = 1'b1;
    wait_idle();
    for (int g = 0; g < 2; g++) begin
      push(g, 0, 1'b1, 8'h01, 8'h03, 1'b0, 0);
      push(g, 0, 1'b1, 8'h01, 8'h03, 1'b0, 0);
      push(g, 1, 1'b1, 8'h02, 8'h01, 1'b0, 0);
    end
    wait_idle();
    for (int g = 0; g < 2; g++) push(g, 1, 1'b0, 8'h04, 8'h00, 1'b1, 0);
    wait_idle();
    for (int g = 0; g < 2; g++) push(g, 0, 1'b0, 8'h00, 8'h00, 1'b0, 0);
    n = 0;
    while (n < 20 && !prd[0]) begin
      tick();
      n++;
    end
    chk("strobe_before_reset", prd[0], 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_idle();
    for (int i = 0; i < 50; i++)
      for (int g = 0; g < 2; g++)
        for (int m = 0; m < 2; m++)
          push(g, m, 1'($urandom % 2), 8'($urandom % 8), 8'($urandom), ($urandom % 4) == 0, int'($urandom % 3));
    wait_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
